// File: rtl/ibnalhaytham_core.sv
// Single-cycle RV32I core: each qualified step executes la_data_in against the PC.
// Register file, data RAM and status flags are flops cleared by the asynchronous reset.
module ibnalhaytham_core (
    input  logic        wb_clk_i,
    input  logic [31:0] la_data_in,
    output logic [31:0] la_data_out,
    input  logic [31:0] la_oenb,
    input  logic [6:0]  io_in,
    output logic [20:0] io_out,
    input  logic        rst_n
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'h37,
        OP_AUIPC  = 7'h17,
        OP_JAL    = 7'h6F,
        OP_JALR   = 7'h67,
        OP_BRANCH = 7'h63,
        OP_LOAD   = 7'h03,
        OP_STORE  = 7'h23,
        OP_IMM    = 7'h13,
        OP_REG    = 7'h33,
        OP_FENCE  = 7'h0F,
        OP_SYSTEM = 7'h73
    } opcode_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q  [32];
    logic [31:0] rf_d  [32];
    logic [31:0] ram_q [16];
    logic [31:0] ram_d [16];
    logic        taken_q, taken_d;
    logic        illegal_q, illegal_d;
    logic        ack_q, ack_d;

    logic [31:0] instr;
    opcode_e     op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [3:0]  ld_idx, st_idx;
    logic        commit;
    logic        br_cond;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] dbg_word;

    assign instr  = la_data_in;
    assign op     = opcode_e'(instr[6:0]);
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign commit = io_in[0] & (la_oenb == 32'd0);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val  = rf_q[rs1];
    assign rs2_val  = rf_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    // Only word address bits [5:2] select a RAM entry; the rest alias.
    assign ld_idx = 4'((rs1_val + imm_i) >> 2);
    assign st_idx = 4'((rs1_val + imm_s) >> 2);

    function automatic logic [31:0] alu(input logic [2:0]  fn,
                                        input logic        alt,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (fn)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        br_cond = 1'b0;
        case (f3)
            3'b000:  br_cond = (rs1_val == rs2_val);
            3'b001:  br_cond = (rs1_val != rs2_val);
            3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond = (rs1_val <  rs2_val);
            3'b111:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
    end

    // NOTE: every output of this block is given a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        pc_d      = pc_q;
        rf_d      = rf_q;
        ram_d     = ram_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        ack_d     = commit;
        wr_en     = 1'b0;
        wr_data   = '0;

        if (commit) begin
            pc_d    = pc_plus4;
            taken_d = 1'b0;
            case (op)
                OP_LUI: begin
                    wr_en   = 1'b1;
                    wr_data = imm_u;
                end
                OP_AUIPC: begin
                    wr_en   = 1'b1;
                    wr_data = pc_q + imm_u;
                end
                OP_JAL: begin
                    wr_en   = 1'b1;
                    wr_data = pc_plus4;
                    pc_d    = pc_q + imm_j;
                    taken_d = 1'b1;
                end
                OP_JALR: begin
                    wr_en   = 1'b1;
                    wr_data = pc_plus4;
                    pc_d    = (rs1_val + imm_i) & ~32'h3;
                    taken_d = 1'b1;
                end
                OP_BRANCH: begin
                    if (br_cond) begin
                        pc_d    = pc_q + imm_b;
                        taken_d = 1'b1;
                    end
                end
                OP_LOAD: begin
                    wr_en   = 1'b1;
                    wr_data = ram_q[ld_idx];
                end
                OP_STORE: ram_d[st_idx] = rs2_val;
                OP_IMM: begin
                    wr_en   = 1'b1;
                    wr_data = alu(f3, (f3 == 3'b101) & instr[30], rs1_val, imm_i);
                end
                OP_REG: begin
                    wr_en   = 1'b1;
                    wr_data = alu(f3, instr[30], rs1_val, rs2_val);
                end
                OP_FENCE, OP_SYSTEM: ;
                default: illegal_d = 1'b1;
            endcase
            if (wr_en && (rd != 5'd0)) rf_d[rd] = wr_data;
        end
    end

    // NOTE: the register file and RAM must come up cleared, so they are plain flops
    // under the asynchronous reset rather than an inferred memory macro.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            rf_q      <= '{default: '0};
            ram_q     <= '{default: '0};
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rf_q      <= rf_d;
            ram_q     <= ram_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            ack_q     <= ack_d;
        end
    end

    assign dbg_word    = rf_q[io_in[5:1]];
    assign la_data_out = pc_q;
    assign io_out      = {2'b00, ack_q, illegal_q, taken_q,
                          io_in[6] ? dbg_word[31:16] : dbg_word[15:0]};

endmodule

// File: tb/tb_ibnalhaytham_core.sv
// Directed-vector bench for ibnalhaytham_core: hand-encoded RV32I instructions with
// hand-computed PC, flag and register values read back through the debug port.
module tb_ibnalhaytham_core;

    logic        wb_clk_i;
    logic [31:0] la_data_in;
    logic [31:0] la_data_out;
    logic [31:0] la_oenb;
    logic [6:0]  io_in;
    logic [20:0] io_out;
    logic        rst_n;

    int n_vec = 0;
    int n_bad = 0;

    ibnalhaytham_core dut (
        .wb_clk_i    (wb_clk_i),
        .la_data_in  (la_data_in),
        .la_data_out (la_data_out),
        .la_oenb     (la_oenb),
        .io_in       (io_in),
        .io_out      (io_out),
        .rst_n       (rst_n)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an instruction with step high; returns #1 after the commit edge.
    task automatic commit(input logic [31:0] ins);
        @(negedge wb_clk_i);
        la_data_in = ins;
        la_oenb    = '0;
        io_in[0]   = 1'b1;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle();
        @(negedge wb_clk_i);
        io_in[0] = 1'b0;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic read_half(input logic [4:0] idx, input logic hi, output logic [15:0] v);
        io_in[5:1] = idx;
        io_in[6]   = hi;
        #1;
        v = io_out[15:0];
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        logic [15:0] lo, hi;
        read_half(idx, 1'b0, lo);
        read_half(idx, 1'b1, hi);
        check(tag, {hi, lo}, exp);
    endtask

    initial begin
        logic [15:0] h;
        rst_n      = 1'b0;
        la_data_in = 32'h0050_0093;
        la_oenb    = '0;
        io_in      = '0;

        // Reset held while step toggles: nothing may commit.
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            io_in[0] = ~io_in[0];
        end
        #1;
        check("rst_pc", la_data_out, 32'd0);
        check("rst_io", {11'd0, io_out}, 32'd0);
        check_reg("rst_x1", 5'd1, 32'd0);

        @(negedge wb_clk_i);
        io_in = '0;
        rst_n = 1'b1;

        commit(32'h0050_0093);                 // ADDI x1,x0,5
        check("addi_pc", la_data_out, 32'd4);
        check("addi_ack", {31'd0, io_out[18]}, 32'd1);
        read_half(5'd1, 1'b0, h);
        check("addi_x1_lo", {16'd0, h}, 32'd5);
        idle();
        check("idle_ack", {31'd0, io_out[18]}, 32'd0);
        check("idle_pc", la_data_out, 32'd4);

        commit(32'hFFF0_0113);                 // ADDI x2,x0,-1
        check("addi2_pc", la_data_out, 32'd8);
        read_half(5'd2, 1'b0, h);
        check("x2_lo", {16'd0, h}, 32'h0000_FFFF);
        read_half(5'd2, 1'b1, h);
        check("x2_hi", {16'd0, h}, 32'h0000_FFFF);

        commit(32'h0000_0463);                 // BEQ x0,x0,+8
        check("beq_pc", la_data_out, 32'd16);
        check("beq_taken", {31'd0, io_out[16]}, 32'd1);

        commit(32'h4020_81B3);                 // SUB x3,x1,x2
        check("sub_pc", la_data_out, 32'd20);
        check("sub_taken", {31'd0, io_out[16]}, 32'd0);
        check_reg("sub_x3", 5'd3, 32'd6);

        commit(32'h0010_2223);                 // SW x1,4(x0)
        commit(32'h0040_2203);                 // LW x4,4(x0), back-to-back
        check("lw_pc", la_data_out, 32'd28);
        check_reg("lw_x4", 5'd4, 32'd5);

        commit(32'h0011_22B3);                 // SLT x5,x2,x1: -1 < 5
        check_reg("slt_x5", 5'd5, 32'd1);
        commit(32'h0011_3333);                 // SLTU x6,x2,x1: 0xFFFFFFFF < 5 is false
        check_reg("sltu_x6", 5'd6, 32'd0);
        commit(32'h01C1_5393);                 // SRLI x7,x2,28
        check_reg("srli_x7", 5'd7, 32'h0000_000F);
        commit(32'h8000_04B7);                 // LUI x9,0x80000
        check_reg("lui_x9", 5'd9, 32'h8000_0000);
        commit(32'h4044_D413);                 // SRAI x8,x9,4
        check_reg("srai_x8", 5'd8, 32'hF800_0000);
        commit(32'h0030_9513);                 // SLLI x10,x1,3
        check("slli_pc", la_data_out, 32'd52);
        check_reg("slli_x10", 5'd10, 32'h0000_0028);

        commit(32'h0080_05EF);                 // JAL x11,+8 at PC 52
        check("jal_pc", la_data_out, 32'd60);
        check_reg("jal_x11", 5'd11, 32'd56);
        commit(32'h0030_8667);                 // JALR x12,3(x1): (5+3)&~3
        check("jalr_pc", la_data_out, 32'd8);
        check("jalr_taken", {31'd0, io_out[16]}, 32'd1);
        check_reg("jalr_x12", 5'd12, 32'd64);

        commit(32'h0000_1463);                 // BNE x0,x0,+8: not taken
        check("bne_pc", la_data_out, 32'd12);
        check("bne_taken", {31'd0, io_out[16]}, 32'd0);

        // Step with a nonzero qualifier must not commit.
        @(negedge wb_clk_i);
        la_data_in = 32'h0070_0093;            // ADDI x1,x0,7
        la_oenb    = 32'h0000_0001;
        io_in[0]   = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("qual_pc", la_data_out, 32'd12);
        check("qual_ack", {31'd0, io_out[18]}, 32'd0);
        check_reg("qual_x1", 5'd1, 32'd5);

        commit(32'h0000_0000);                 // illegal all-zero opcode
        check("ill_pc", la_data_out, 32'd16);
        check("ill_flag", {31'd0, io_out[17]}, 32'd1);
        commit(32'h0000_000F);                 // FENCE: NOP
        commit(32'h0090_0093);                 // ADDI x1,x0,9
        check("ill_sticky", {31'd0, io_out[17]}, 32'd1);
        check("ill_after_pc", la_data_out, 32'd24);
        check_reg("ill_after_x1", 5'd1, 32'd9);

        // Asynchronous reset mid-cycle clears everything at once.
        @(negedge wb_clk_i);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", la_data_out, 32'd0);
        check("mid_rst_io", {11'd0, io_out[20:16]}, 32'd0);
        check_reg("mid_rst_x1", 5'd1, 32'd0);
        @(negedge wb_clk_i);
        io_in[0] = 1'b0;
        rst_n    = 1'b1;

        commit(32'h0040_2203);                 // LW x4,4(x0): RAM was cleared
        check_reg("rst_ram_x4", 5'd4, 32'd0);
        commit(32'h0000_1717);                 // AUIPC x14,1 at PC 4
        check_reg("auipc_x14", 5'd14, 32'h0000_1004);
        check("auipc_pc", la_data_out, 32'd8);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
